// File: rtl/tmma_left_feeder_if.sv
// Bundle of the control, row-buffer and PE left-edge signals of one row feeder.
`ifndef SARRAY_W
`define SARRAY_W 4
`endif
`ifndef PE_INPUT_DATA_WIDTH
`define PE_INPUT_DATA_WIDTH 16
`endif
`ifndef TMMA_CNT_WIDTH
`define TMMA_CNT_WIDTH 8
`endif
`ifndef TMMA_PRECISION_WIDTH
`define TMMA_PRECISION_WIDTH 2
`endif
`ifndef PE_DATA_TYPE_C
`define PE_DATA_TYPE_C 1'b1
`endif
`ifndef PE_DATA_TYPE_A
`define PE_DATA_TYPE_A 1'b0
`endif

interface tmma_left_feeder_if #(
  parameter int unsigned ADDR_W = 10
);
  localparam int unsigned DATA_W = `PE_INPUT_DATA_WIDTH;
  localparam int unsigned CNT_W  = `TMMA_CNT_WIDTH;
  localparam int unsigned PREC_W = `TMMA_PRECISION_WIDTH;

  logic              start_i;
  logic              load_c_i;
  logic [CNT_W-1:0]  k_i;
  logic [PREC_W-1:0] precision_i;
  logic [ADDR_W-1:0] c_base_i;
  logic [ADDR_W-1:0] a_base_i;
  logic              busy_o;
  logic              done_o;
  logic              rd_en_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [DATA_W-1:0] rd_data_i;
  logic              left_data_valid_o;
  logic [CNT_W-1:0]  left_data_cnt_o;
  logic              left_data_type_o;
  logic [PREC_W-1:0] left_precision_o;
  logic [DATA_W-1:0] left_data_o;

  // Feeder side
  modport slave (
    input  start_i, load_c_i, k_i, precision_i, c_base_i, a_base_i, rd_data_i,
    output busy_o, done_o, rd_en_o, rd_addr_o,
    output left_data_valid_o, left_data_cnt_o, left_data_type_o,
    output left_precision_o, left_data_o
  );

  // Controller / row-buffer / PE side
  modport master (
    output start_i, load_c_i, k_i, precision_i, c_base_i, a_base_i, rd_data_i,
    input  busy_o, done_o, rd_en_o, rd_addr_o,
    input  left_data_valid_o, left_data_cnt_o, left_data_type_o,
    input  left_precision_o, left_data_o
  );
endinterface

// File: rtl/tmma_left_feeder.sv
// Left-edge feeder for one systolic array row: reads C then A words, tags and skews them by ROW.
`ifndef SARRAY_W
`define SARRAY_W 4
`endif
`ifndef PE_INPUT_DATA_WIDTH
`define PE_INPUT_DATA_WIDTH 16
`endif
`ifndef TMMA_CNT_WIDTH
`define TMMA_CNT_WIDTH 8
`endif
`ifndef TMMA_PRECISION_WIDTH
`define TMMA_PRECISION_WIDTH 2
`endif
`ifndef PE_DATA_TYPE_C
`define PE_DATA_TYPE_C 1'b1
`endif
`ifndef PE_DATA_TYPE_A
`define PE_DATA_TYPE_A 1'b0
`endif

module tmma_left_feeder #(
  parameter int unsigned ROW      = 0,
  parameter int unsigned SARRAY_W = `SARRAY_W,
  parameter int unsigned ADDR_W   = 10
) (
  input logic               clk,
  input logic               rst,
  tmma_left_feeder_if.slave bus
);
  localparam int unsigned DATA_W = `PE_INPUT_DATA_WIDTH;
  localparam int unsigned CNT_W  = `TMMA_CNT_WIDTH;
  localparam int unsigned PREC_W = `TMMA_PRECISION_WIDTH;
  // pipe word: {valid, last, type, cnt, data}
  localparam int unsigned PIPE_W = 3 + CNT_W + DATA_W;

  typedef enum logic [1:0] {IDLE, RD_C, RD_A, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    k_l;
  logic [PREC_W-1:0]   prec_l;
  logic [ADDR_W-1:0]   c_base_l, a_base_l;
  logic                start_acc;

  logic [CNT_W-1:0]    k_d;
  logic [ADDR_W-1:0]   c_base_d, a_base_d;
  logic                rd_en_d, iss_type_d, iss_last_d, busy_d, done_empty_d;
  logic [ADDR_W-1:0]   rd_addr_d;
  logic [CNT_W-1:0]    iss_cnt_d;

  logic                rd_en_q, iss_type_q, iss_last_q, busy_q, done_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [CNT_W-1:0]    iss_cnt_q;

  logic                lat_valid_q, lat_last_q, lat_type_q;
  logic [CNT_W-1:0]    lat_cnt_q;

  logic [PIPE_W-1:0]   pipe_in, pipe_out;

  logic                out_valid_q, out_type_q;
  logic [CNT_W-1:0]    out_cnt_q;
  logic [PREC_W-1:0]   out_prec_q;
  logic [DATA_W-1:0]   out_data_q;

  assign start_acc = bus.start_i && (state_q == IDLE);

  // State register plus per-operation latched parameters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      k_l      <= '0;
      prec_l   <= '0;
      c_base_l <= '0;
      a_base_l <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (start_acc) begin
        k_l      <= bus.k_i;
        prec_l   <= bus.precision_i;
        c_base_l <= bus.c_base_i;
        a_base_l <= bus.a_base_i;
      end
    end
  end

  // Next-state: one read per cycle in RD_C/RD_A, DRAIN until the last word is out
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (start_acc) begin
          idx_d = '0;
          if (bus.load_c_i)       state_d = RD_C;
          else if (bus.k_i != '0) state_d = RD_A;
          else                    state_d = DRAIN;
        end
      end
      RD_C: begin
        if (idx_q == CNT_W'(SARRAY_W - 1)) begin
          idx_d   = '0;
          state_d = (k_l != '0) ? RD_A : DRAIN;
        end else begin
          idx_d = idx_q + CNT_W'(1);
        end
      end
      RD_A: begin
        if (idx_q == k_l - CNT_W'(1)) begin
          idx_d   = '0;
          state_d = DRAIN;
        end else begin
          idx_d = idx_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (done_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: next-cycle read request and tag derived from the next state
  always_comb begin
    k_d          = start_acc ? bus.k_i      : k_l;
    c_base_d     = start_acc ? bus.c_base_i : c_base_l;
    a_base_d     = start_acc ? bus.a_base_i : a_base_l;
    rd_en_d      = 1'b0;
    rd_addr_d    = '0;
    iss_type_d   = 1'b0;
    iss_cnt_d    = '0;
    iss_last_d   = 1'b0;
    busy_d       = (state_d != IDLE);
    done_empty_d = start_acc && !bus.load_c_i && (bus.k_i == '0);
    unique case (state_d)
      RD_C: begin
        rd_en_d    = 1'b1;
        rd_addr_d  = c_base_d + ADDR_W'(idx_d);
        iss_type_d = `PE_DATA_TYPE_C;
        iss_cnt_d  = idx_d + CNT_W'(1);
        iss_last_d = (idx_d == CNT_W'(SARRAY_W - 1)) && (k_d == '0);
      end
      RD_A: begin
        rd_en_d    = 1'b1;
        rd_addr_d  = a_base_d + ADDR_W'(idx_d);
        iss_type_d = `PE_DATA_TYPE_A;
        iss_cnt_d  = idx_d;
        iss_last_d = (idx_d == k_d - CNT_W'(1));
      end
      default: ;
    endcase
  end

  // Read-issue registers and tag entering the pipeline with the read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      iss_type_q <= 1'b0;
      iss_cnt_q  <= '0;
      iss_last_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      iss_type_q <= iss_type_d;
      iss_cnt_q  <= iss_cnt_d;
      iss_last_q <= iss_last_d;
      busy_q     <= busy_d;
    end
  end

  // Read-latency stage: tag aligns with rd_data_i
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_valid_q <= 1'b0;
      lat_last_q  <= 1'b0;
      lat_type_q  <= 1'b0;
      lat_cnt_q   <= '0;
    end else begin
      lat_valid_q <= rd_en_q;
      lat_last_q  <= iss_last_q;
      lat_type_q  <= iss_type_q;
      lat_cnt_q   <= iss_cnt_q;
    end
  end

  assign pipe_in = {lat_valid_q, lat_last_q, lat_type_q, lat_cnt_q, bus.rd_data_i};

  if (ROW == 0) begin : g_noskew
    assign pipe_out = pipe_in;
  end else begin : g_skew
    logic [PIPE_W-1:0] skew_q [ROW];
    // ROW-deep skew shift register
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < int'(ROW); i++) skew_q[i] <= '0;
      end else begin
        skew_q[0] <= pipe_in;
        for (int i = 1; i < int'(ROW); i++) skew_q[i] <= skew_q[i-1];
      end
    end
    assign pipe_out = skew_q[ROW-1];
  end

  // Output register: fields zeroed when invalid, done coincides with the last word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_type_q  <= 1'b0;
      out_cnt_q   <= '0;
      out_prec_q  <= '0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      out_valid_q <= pipe_out[PIPE_W-1];
      out_type_q  <= pipe_out[PIPE_W-1] ? pipe_out[PIPE_W-3] : 1'b0;
      out_cnt_q   <= pipe_out[PIPE_W-1] ? pipe_out[DATA_W +: CNT_W] : '0;
      out_prec_q  <= pipe_out[PIPE_W-1] ? prec_l : '0;
      out_data_q  <= pipe_out[PIPE_W-1] ? pipe_out[DATA_W-1:0] : '0;
      done_q      <= done_empty_d || (pipe_out[PIPE_W-1] && pipe_out[PIPE_W-2]);
    end
  end

  assign bus.busy_o            = busy_q;
  assign bus.done_o            = done_q;
  assign bus.rd_en_o           = rd_en_q;
  assign bus.rd_addr_o         = rd_addr_q;
  assign bus.left_data_valid_o = out_valid_q;
  assign bus.left_data_cnt_o   = out_cnt_q;
  assign bus.left_data_type_o  = out_type_q;
  assign bus.left_precision_o  = out_prec_q;
  assign bus.left_data_o       = out_data_q;
endmodule

// File: tb/tb_tmma_left_feeder.sv
// Scoreboard bench for tmma_left_feeder: spec-level timing/address/tag model vs monitored outputs.
`ifndef SARRAY_W
`define SARRAY_W 4
`endif
`ifndef PE_INPUT_DATA_WIDTH
`define PE_INPUT_DATA_WIDTH 16
`endif
`ifndef TMMA_CNT_WIDTH
`define TMMA_CNT_WIDTH 8
`endif
`ifndef TMMA_PRECISION_WIDTH
`define TMMA_PRECISION_WIDTH 2
`endif
`ifndef PE_DATA_TYPE_C
`define PE_DATA_TYPE_C 1'b1
`endif
`ifndef PE_DATA_TYPE_A
`define PE_DATA_TYPE_A 1'b0
`endif

module tb_tmma_left_feeder;
  localparam int unsigned ROW = 2;
  localparam int unsigned SW  = 4;
  localparam int unsigned AW  = 10;
  localparam int unsigned DW  = `PE_INPUT_DATA_WIDTH;
  localparam int unsigned CW  = `TMMA_CNT_WIDTH;
  localparam int unsigned PW  = `TMMA_PRECISION_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tmma_left_feeder_if #(.ADDR_W(AW)) bus();

  tmma_left_feeder #(.ROW(ROW), .SARRAY_W(SW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous row buffer: data valid the cycle after the address
  logic [DW-1:0] mem [1<<AW];
  always @(posedge clk) bus.rd_data_i <= mem[bus.rd_addr_o];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic          typ;
    logic [CW-1:0] cnt;
    logic [DW-1:0] data;
    logic [PW-1:0] prec;
    int            cyc;
  } word_t;
  typedef struct {
    logic [AW-1:0] addr;
    int            cyc;
  } rd_t;

  word_t word_q[$];
  rd_t   rd_q[$];
  int    done_q[$];
  int    busy_from = 1;
  int    busy_to   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event with nothing expected (cycle %0d)", name, cyc);
  endtask

  // Reference model: expected reads, words and done cycle for a start accepted in cycle t
  task automatic model_op(input logic lc, input int k, input logic [AW-1:0] cb,
                          input logic [AW-1:0] ab, input logic [PW-1:0] prec,
                          input int t, output int done_cyc);
    int n;
    logic [AW-1:0] a;
    word_t w;
    rd_t r;
    n = 0;
    if (lc) begin
      for (int i = 0; i < int'(SW); i++) begin
        a = cb + AW'(i);
        r.addr = a; r.cyc = t + 1 + n; rd_q.push_back(r);
        w.typ = `PE_DATA_TYPE_C; w.cnt = CW'(i + 1); w.data = mem[a];
        w.prec = prec; w.cyc = t + 3 + int'(ROW) + n;
        word_q.push_back(w);
        n++;
      end
    end
    for (int j = 0; j < k; j++) begin
      a = ab + AW'(j);
      r.addr = a; r.cyc = t + 1 + n; rd_q.push_back(r);
      w.typ = `PE_DATA_TYPE_A; w.cnt = CW'(j); w.data = mem[a];
      w.prec = prec; w.cyc = t + 3 + int'(ROW) + n;
      word_q.push_back(w);
      n++;
    end
    done_cyc = (n > 0) ? t + 2 + int'(ROW) + n : t + 1;
    done_q.push_back(done_cyc);
    busy_from = t + 1;
    busy_to   = done_cyc;
  endtask

  // Issue a start on the current negedge; returns the expected done cycle
  task automatic issue(input logic lc, input int k, input logic [AW-1:0] cb,
                       input logic [AW-1:0] ab, input logic [PW-1:0] prec,
                       output int t, output int done_cyc);
    bus.load_c_i    = lc;
    bus.k_i         = CW'(k);
    bus.c_base_i    = cb;
    bus.a_base_i    = ab;
    bus.precision_i = prec;
    bus.start_i     = 1'b1;
    t = cyc;
    model_op(lc, k, cb, ab, prec, t, done_cyc);
  endtask

  // Full operation; inputs scrambled while busy, optional extra starts at T+3 and the done cycle
  task automatic run_op(input logic lc, input int k, input logic [AW-1:0] cb,
                        input logic [AW-1:0] ab, input logic [PW-1:0] prec, input bit extra);
    int t, dc;
    issue(lc, k, cb, ab, prec, t, dc);
    @(negedge clk);
    while (cyc <= dc) begin
      bus.start_i     = extra && (cyc == t + 3 || cyc == dc);
      bus.load_c_i    = 1'($urandom);
      bus.k_i         = CW'($urandom_range(1, 9));
      bus.c_base_i    = AW'($urandom);
      bus.a_base_i    = AW'($urandom);
      bus.precision_i = PW'($urandom);
      @(negedge clk);
    end
    bus.start_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},  64'(bus.busy_o), 64'(0));
    chk({tag, "_done"},  64'(bus.done_o), 64'(0));
    chk({tag, "_rd_en"}, 64'(bus.rd_en_o), 64'(0));
    chk({tag, "_rd_addr"}, 64'(bus.rd_addr_o), 64'(0));
    chk({tag, "_valid"}, 64'(bus.left_data_valid_o), 64'(0));
    chk({tag, "_cnt"},   64'(bus.left_data_cnt_o), 64'(0));
    chk({tag, "_type"},  64'(bus.left_data_type_o), 64'(0));
    chk({tag, "_prec"},  64'(bus.left_precision_o), 64'(0));
    chk({tag, "_data"},  64'(bus.left_data_o), 64'(0));
  endtask

  // Monitor: pops and compares every read, output word and done pulse
  always @(negedge clk) begin
    if (!rst) begin
      rd_t   r;
      word_t w;
      int    d;
      chk("busy", 64'(bus.busy_o), 64'((cyc >= busy_from) && (cyc <= busy_to)));
      if (bus.rd_en_o) begin
        if (rd_q.size() == 0) unexpected("rd_en");
        else begin
          r = rd_q.pop_front();
          chk("rd_addr", 64'(bus.rd_addr_o), 64'(r.addr));
          chk("rd_cycle", 64'(cyc), 64'(r.cyc));
        end
      end
      if (bus.left_data_valid_o) begin
        if (word_q.size() == 0) unexpected("left_valid");
        else begin
          w = word_q.pop_front();
          chk("out_cycle", 64'(cyc), 64'(w.cyc));
          chk("out_type", 64'(bus.left_data_type_o), 64'(w.typ));
          chk("out_cnt", 64'(bus.left_data_cnt_o), 64'(w.cnt));
          chk("out_data", 64'(bus.left_data_o), 64'(w.data));
          chk("out_prec", 64'(bus.left_precision_o), 64'(w.prec));
        end
      end else begin
        chk("idle_fields", 64'({bus.left_data_o, bus.left_data_cnt_o,
                                bus.left_data_type_o, bus.left_precision_o}), 64'(0));
      end
      if (bus.done_o) begin
        if (done_q.size() == 0) unexpected("done");
        else begin
          d = done_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(d));
        end
      end
    end
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, dc;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    bus.start_i = 1'b0; bus.load_c_i = 1'b0; bus.k_i = '0;
    bus.precision_i = '0; bus.c_base_i = '0; bus.a_base_i = '0;

    // Power-up reset
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // C then A with ignored starts, then back-to-back start with new parameters
    run_op(1'b1, 3, AW'('h10), AW'('h20), PW'(1), 1'b1);
    run_op(1'b0, 5, AW'('h55), AW'('h100), PW'(2), 1'b1);
    repeat (2) @(negedge clk);

    // Empty operations, back to back
    run_op(1'b0, 0, AW'('h0), AW'('h0), PW'(3), 1'b1);
    run_op(1'b0, 0, AW'('h7), AW'('h9), PW'(1), 1'b0);
    repeat (1) @(negedge clk);

    // Address wrap
    run_op(1'b0, 4, AW'('h0), AW'('h3FE), PW'(3), 1'b0);
    run_op(1'b1, 2, AW'('h3FD), AW'('h3FF), PW'(2), 1'b0);

    // Reset in the cycle after the second valid output
    issue(1'b1, 3, AW'('h40), AW'('h80), PW'(2), t, dc);
    @(negedge clk);
    bus.start_i = 1'b0;
    while (cyc < t + 5 + int'(ROW)) @(negedge clk);
    #2;
    rst = 1'b1;
    word_q.delete(); rd_q.delete(); done_q.delete();
    busy_from = 1; busy_to = 0;
    #1;
    check_all_zero("midop_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run_op(1'b0, 2, AW'('h33), AW'('h1F0), PW'(1), 1'b0);

    // Randomized operations with random gaps
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(1'($urandom), int'($urandom_range(0, 7)), AW'($urandom), AW'($urandom),
             PW'($urandom), 1'($urandom));
    end

    repeat (ROW + 8) @(negedge clk);
    chk("pending_words", 64'(word_q.size()), 64'(0));
    chk("pending_reads", 64'(rd_q.size()), 64'(0));
    chk("pending_done", 64'(done_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
